// File: rtl/avr_regfile_mp.sv
// ---------------------------------------------------------------------------
// avr_regfile_mp
//
// Multi-port general-purpose register file for the AVR-style core. It has
// NUM_RD registered read ports, each able to read one byte or an aligned
// byte pair, and two write ports. Port A writes a byte or an aligned pair.
// Port B writes a byte only. An X/Y/Z pointer unit does a single-edge
// read-modify-write for post-increment and pre-decrement addressing.
//
// Parameters
//   DATA_WIDTH  register width in bits (default 8)
//   ADDR_WIDTH  register index width, depth = 2**ADDR_WIDTH, minimum 3
//   NUM_RD      number of read ports, 1..4
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset, clears every register
//   rd_en      per-port read strobe; a port with rd_en low holds its result
//   rd_word    per-port pair read ({mem[a|1], mem[a&~1]}), else byte read
//   rd_addr    port i index in slice i
//   rd_data    port i result in slice i as {high, low}; byte reads give
//              a zero high byte
//   wa_en      write port A enable
//   wa_word    port A pair write, else byte write of wa_data low byte
//   wa_addr    port A index (LSB ignored for pair writes)
//   wa_data    port A data {high, low}
//   wb_en      write port B enable (byte only)
//   wb_addr    port B index
//   wb_data    port B data
//   ptr_op     00 none, 01 post-increment, 10 pre-decrement, 11 no-op
//   ptr_sel    00 X, 01 Y, 10 Z, 11 invalid
//   ptr_q      effective address from the last pointer operation
//   collision  one-cycle flag: two write sources hit the same byte
//   ptr_err    one-cycle flag: pointer operation requested on ptr_sel 11
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of a byte written on the same
//                      edge returns the new (post-priority) value. When it
//                      is undefined, such a read returns the old contents.
// ---------------------------------------------------------------------------
module avr_regfile_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD-1:0]              rd_word,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*2*DATA_WIDTH-1:0] rd_data,
    input  logic                           wa_en,
    input  logic                           wa_word,
    input  logic [ADDR_WIDTH-1:0]          wa_addr,
    input  logic [2*DATA_WIDTH-1:0]        wa_data,
    input  logic                           wb_en,
    input  logic [ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic [1:0]                     ptr_op,
    input  logic [1:0]                     ptr_sel,
    output logic [2*DATA_WIDTH-1:0]        ptr_q,
    output logic                           collision,
    output logic                           ptr_err
);

    localparam int DW    = DATA_WIDTH;
    localparam int AW    = ADDR_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Pointer pairs sit in the top six entries: X, Y, Z from low to high.
    localparam logic [AW-1:0] PTR_BASE = AW'(DEPTH - 6);

    // Pointer arithmetic wraps modulo 2**PW.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return p - PW'(1);
    endfunction

    // Storage and registered outputs
    logic [DW-1:0]        mem      [DEPTH];
    logic [DW-1:0]        mem_next [DEPTH];
    logic [DW-1:0]        rd_src   [DEPTH];
    logic [PW-1:0]        rd_val   [NUM_RD];

    logic [NUM_RD*PW-1:0] rd_data_p1;
    logic [PW-1:0]        ptr_q_p1;
    logic                 coll_p1;
    logic                 err_p1;

    // Per-byte write hit vectors
    logic [DEPTH-1:0]     hit_p;
    logic [DEPTH-1:0]     hit_a;
    logic [DEPTH-1:0]     hit_b;
    logic [DEPTH-1:0]     byte_coll;

    // ---- stage p0: decode pointer request and compute pointer update ----
    logic            ptr_req;
    logic            ptr_act;
    logic            ptr_bad;
    logic            ptr_post;
    logic [AW-1:0]   ptr_lo_idx;
    logic [AW-1:0]   ptr_hi_idx;
    logic [PW-1:0]   ptr_cur;
    logic [PW-1:0]   ptr_new;
    logic [PW-1:0]   ptr_eff;

    assign ptr_req    = (ptr_op == 2'b01) || (ptr_op == 2'b10);
    assign ptr_act    = ptr_req && (ptr_sel != 2'b11);
    assign ptr_bad    = ptr_req && (ptr_sel == 2'b11);
    assign ptr_post   = (ptr_op == 2'b01);

    // For ptr_sel 11 this index wraps, but ptr_act masks every use of it.
    assign ptr_lo_idx = PTR_BASE + AW'({ptr_sel, 1'b0});
    assign ptr_hi_idx = ptr_lo_idx | AW'(1);

    // The pointer reads the pre-edge contents, so chained operations on one
    // pointer see each other's results through the storage, one edge apart.
    assign ptr_cur    = {mem[ptr_hi_idx], mem[ptr_lo_idx]};
    assign ptr_new    = ptr_post ? ptr_inc(ptr_cur) : ptr_dec(ptr_cur);
    assign ptr_eff    = ptr_post ? ptr_cur : ptr_new;

    // Per-byte write resolution: pointer unit beats port A beats port B.
    for (genvar j = 0; j < DEPTH; j++) begin : g_byte
        localparam logic [AW-1:0] IDX = AW'(j);

        assign hit_p[j] = ptr_act &&
                          ((IDX == ptr_lo_idx) || (IDX == ptr_hi_idx));
        assign hit_a[j] = wa_en &&
                          (wa_word ? (IDX[AW-1:1] == wa_addr[AW-1:1])
                                   : (IDX == wa_addr));
        assign hit_b[j] = wb_en && (IDX == wb_addr);

        assign byte_coll[j] = (hit_p[j] & hit_a[j]) |
                              (hit_p[j] & hit_b[j]) |
                              (hit_a[j] & hit_b[j]);

        // Odd indices take the high half of a pair, even ones the low half.
        assign mem_next[j] =
            hit_p[j] ? (IDX[0] ? ptr_new[PW-1:DW] : ptr_new[DW-1:0]) :
            hit_a[j] ? ((wa_word && IDX[0]) ? wa_data[PW-1:DW]
                                            : wa_data[DW-1:0]) :
            hit_b[j] ? wb_data :
                       mem[j];

`ifdef REGFILE_BYPASS_EN
        assign rd_src[j] = mem_next[j];
`else
        assign rd_src[j] = mem[j];
`endif
    end

    // Read selection per port
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [AW-1:0] addr_lo;
        logic [AW-1:0] addr_hi;

        assign addr    = rd_addr[i*AW +: AW];
        assign addr_lo = {addr[AW-1:1], 1'b0};
        assign addr_hi = {addr[AW-1:1], 1'b1};

        assign rd_val[i] = rd_word[i] ? {rd_src[addr_hi], rd_src[addr_lo]}
                                      : {{DW{1'b0}}, rd_src[addr]};
    end

    // ---- stage p1: commit writes and register read / status outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
            rd_data_p1 <= '0;
            ptr_q_p1   <= '0;
            coll_p1    <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= mem_next[j];
            end
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_data_p1[i*PW +: PW] <= rd_val[i];
                end
            end
            if (ptr_act) begin
                ptr_q_p1 <= ptr_eff;
            end
            coll_p1 <= |byte_coll;
            err_p1  <= ptr_bad;
        end
    end

    assign rd_data   = rd_data_p1;
    assign ptr_q     = ptr_q_p1;
    assign collision = coll_p1;
    assign ptr_err   = err_p1;

endmodule

// File: tb/tb_avr_regfile_mp.sv
// Testbench for avr_regfile_mp (default parameters: 8-bit data, 32 entries,
// two read ports). Directed steps follow the block's documented behaviour,
// then randomized traffic is checked against a behavioural model.
module tb_avr_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rd_en;
    logic [1:0]  rd_word;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wa_en;
    logic        wa_word;
    logic [4:0]  wa_addr;
    logic [15:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [1:0]  ptr_op;
    logic [1:0]  ptr_sel;
    logic [15:0] ptr_q;
    logic        collision;
    logic        ptr_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  m_mem [32];
    logic [15:0] m_rd  [2];
    logic [15:0] m_q;
    logic        m_coll;
    logic        m_err;

    avr_regfile_mp #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .NUM_RD    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_word  (rd_word),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wa_en    (wa_en),
        .wa_word  (wa_word),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ptr_op   (ptr_op),
        .ptr_sel  (ptr_sel),
        .ptr_q    (ptr_q),
        .collision(collision),
        .ptr_err  (ptr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 32; j++) m_mem[j] = 8'h00;
        m_rd[0] = 16'h0000;
        m_rd[1] = 16'h0000;
        m_q     = 16'h0000;
        m_coll  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the architectural rules: writes are applied in
    // ascending priority (B, then A, then pointer) so the later one wins.
    task automatic model_step();
        logic [7:0] nm [32];
        int         hits [32];
        int         base, p, np, a, lo;
        logic [7:0] src [32];
        nm = m_mem;
        for (int j = 0; j < 32; j++) hits[j] = 0;
        m_err  = 1'b0;
        m_coll = 1'b0;
        if (wb_en) begin
            nm[int'(wb_addr)] = wb_data;
            hits[int'(wb_addr)]++;
        end
        if (wa_en) begin
            if (wa_word) begin
                lo = (int'(wa_addr) / 2) * 2;
                nm[lo]     = wa_data[7:0];
                nm[lo + 1] = wa_data[15:8];
                hits[lo]++;
                hits[lo + 1]++;
            end else begin
                nm[int'(wa_addr)] = wa_data[7:0];
                hits[int'(wa_addr)]++;
            end
        end
        if (ptr_op == 2'd1 || ptr_op == 2'd2) begin
            if (ptr_sel == 2'd3) begin
                m_err = 1'b1;
            end else begin
                base = 26 + 2 * int'(ptr_sel);
                p    = int'(m_mem[base + 1]) * 256 + int'(m_mem[base]);
                if (ptr_op == 2'd1) begin
                    np  = (p + 1) % 65536;
                    m_q = 16'(p);
                end else begin
                    np  = (p + 65535) % 65536;
                    m_q = 16'(np);
                end
                nm[base]     = 8'(np % 256);
                nm[base + 1] = 8'(np / 256);
                hits[base]++;
                hits[base + 1]++;
            end
        end
        for (int j = 0; j < 32; j++) if (hits[j] >= 2) m_coll = 1'b1;
`ifdef REGFILE_BYPASS_EN
        src = nm;
`else
        src = m_mem;
`endif
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                a  = int'(rd_addr[i*5 +: 5]);
                lo = (a / 2) * 2;
                if (rd_word[i]) m_rd[i] = {src[lo + 1], src[lo]};
                else            m_rd[i] = {8'h00, src[a]};
            end
        end
        m_mem = nm;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rd0"},  {16'h0, rd_data[15:0]},  {16'h0, m_rd[0]});
        chk({tag, ".rd1"},  {16'h0, rd_data[31:16]}, {16'h0, m_rd[1]});
        chk({tag, ".ptrq"}, {16'h0, ptr_q},          {16'h0, m_q});
        chk({tag, ".coll"}, {31'h0, collision},      {31'h0, m_coll});
        chk({tag, ".err"},  {31'h0, ptr_err},        {31'h0, m_err});
    endtask

    task automatic idle();
        rd_en = 2'b00; rd_word = 2'b00; rd_addr = 10'h000;
        wa_en = 1'b0; wa_word = 1'b0; wa_addr = 5'h00; wa_data = 16'h0000;
        wb_en = 1'b0; wb_addr = 5'h00; wb_data = 8'h00;
        ptr_op = 2'b00; ptr_sel = 2'b00;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic rd_port(input int i, input logic word, input logic [4:0] addr);
        rd_en[i]          = 1'b1;
        rd_word[i]        = word;
        rd_addr[i*5 +: 5] = addr;
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reads right after reset
        idle(); rd_port(0, 1'b1, 5'd30); rd_port(1, 1'b0, 5'd5);
        cycle("post_reset_read");
        chk("tp_rd0_zero", {16'h0, rd_data[15:0]}, 32'h0000);
        chk("tp_rd1_zero", {16'h0, rd_data[31:16]}, 32'h0000);

        // Port A pair write, aligned pair read and byte read
        idle(); wa_en = 1'b1; wa_word = 1'b1; wa_addr = 5'd26; wa_data = 16'h1234;
        cycle("wa_word");
        idle(); rd_port(0, 1'b1, 5'd27); rd_port(1, 1'b0, 5'd26);
        cycle("rd_pair");
        chk("tp_word27", {16'h0, rd_data[15:0]}, 32'h1234);
        chk("tp_byte26", {16'h0, rd_data[31:16]}, 32'h0034);

        // Z wraparound: post-increment from FFFF, then pre-decrement from 0000
        idle(); wa_en = 1'b1; wa_word = 1'b1; wa_addr = 5'd30; wa_data = 16'hFFFF;
        cycle("z_set");
        idle(); ptr_op = 2'b01; ptr_sel = 2'b10;
        cycle("z_postinc");
        chk("tp_z_postinc_q", {16'h0, ptr_q}, 32'hFFFF);
        idle(); ptr_op = 2'b10; ptr_sel = 2'b10; rd_port(0, 1'b1, 5'd30);
        cycle("z_predec");
        chk("tp_z_predec_q", {16'h0, ptr_q}, 32'hFFFF);
`ifdef REGFILE_BYPASS_EN
        chk("tp_z_same_edge", {16'h0, rd_data[15:0]}, 32'hFFFF);
`else
        chk("tp_z_same_edge", {16'h0, rd_data[15:0]}, 32'h0000);
`endif
        idle(); rd_port(0, 1'b1, 5'd30);
        cycle("z_read");
        chk("tp_z_final", {16'h0, rd_data[15:0]}, 32'hFFFF);

        // Three-way collision on Y low byte
        idle(); wa_en = 1'b1; wa_word = 1'b1; wa_addr = 5'd28; wa_data = 16'h0010;
        cycle("y_set");
        idle();
        wa_en = 1'b1; wa_word = 1'b0; wa_addr = 5'd28; wa_data = 16'h00AA;
        wb_en = 1'b1; wb_addr = 5'd28; wb_data = 8'h55;
        ptr_op = 2'b01; ptr_sel = 2'b01;
        cycle("y_collide");
        chk("tp_coll_set", {31'h0, collision}, 32'h1);
        chk("tp_coll_q", {16'h0, ptr_q}, 32'h0010);
        idle(); rd_port(0, 1'b1, 5'd28);
        cycle("y_read");
        chk("tp_y_value", {16'h0, rd_data[15:0]}, 32'h0011);
        chk("tp_coll_clear", {31'h0, collision}, 32'h0);

        // Same-edge write and read of one byte
        idle(); wb_en = 1'b1; wb_addr = 5'd3; wb_data = 8'h77; rd_port(0, 1'b0, 5'd3);
        cycle("same_edge");
`ifdef REGFILE_BYPASS_EN
        chk("tp_bypass", {16'h0, rd_data[15:0]}, 32'h0077);
`else
        chk("tp_bypass", {16'h0, rd_data[15:0]}, 32'h0000);
`endif

        // Invalid pointer select
        idle(); ptr_op = 2'b01; ptr_sel = 2'b11;
        cycle("ptr_bad");
        chk("tp_err_set", {31'h0, ptr_err}, 32'h1);
        chk("tp_err_q", {16'h0, ptr_q}, 32'h0010);
        idle(); rd_port(0, 1'b1, 5'd26); rd_port(1, 1'b1, 5'd28);
        cycle("ptr_bad_after");
        chk("tp_err_clear", {31'h0, ptr_err}, 32'h0);
        chk("tp_x_kept", {16'h0, rd_data[15:0]}, 32'h1234);

        // Randomized traffic, with a mid-run asynchronous reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                #3;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_all("mid_reset");
                chk("tp_reset_rd", rd_data, 32'h0);
                idle();
                @(negedge clk);
                rst_n = 1'b1;
                wa_en = 1'b1; wa_word = 1'b1; wa_addr = 5'd0; wa_data = 16'hBEEF;
                cycle("first_write");
                idle(); rd_port(0, 1'b1, 5'd1); rd_port(1, 1'b1, 5'd30);
                cycle("first_write_rd");
                chk("tp_first_write", {16'h0, rd_data[15:0]}, 32'hBEEF);
                chk("tp_mem_cleared", {16'h0, rd_data[31:16]}, 32'h0000);
            end
            rd_en   = 2'($urandom);
            rd_word = 2'($urandom);
            rd_addr = 10'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd_addr[4:0] = 5'(24 + $urandom_range(0, 7));
            end
            wa_en   = ($urandom_range(0, 2) != 0);
            wa_word = 1'($urandom);
            wa_addr = ($urandom_range(0, 1) == 1) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom);
            wa_data = 16'($urandom);
            wb_en   = ($urandom_range(0, 2) != 0);
            wb_addr = ($urandom_range(0, 1) == 1) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom);
            wb_data = 8'($urandom);
            ptr_op  = 2'($urandom);
            ptr_sel = 2'($urandom);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
